// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter feeding a single register-file write port.
// Define WB_ARBITER_SCOREBOARD_EN to build the pending-writeback scoreboard on o_busy.
module wb_arbiter #(
    parameter int n_req_p   = 2,
    parameter int n_regs_p  = 32,
    parameter int wd_regs_p = 32,
    parameter int wd_addr_p = $clog2(n_regs_p)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [n_req_p-1:0]                  i_req_valid,
    output logic [n_req_p-1:0]                  o_req_ready,
    input  logic [n_req_p-1:0][wd_addr_p-1:0]   i_req_addr,
    input  logic [n_req_p-1:0][wd_regs_p-1:0]   i_req_data,
    output logic                                o_reg_wr_en,
    output logic [wd_addr_p-1:0]                o_reg_wr_addr,
    output logic [wd_regs_p-1:0]                o_reg_wr_data,
    input  logic                                i_issue_en,
    input  logic [wd_addr_p-1:0]                i_issue_rd,
    output logic [n_regs_p-1:0]                 o_busy
);

    localparam int ptr_w_lp = $clog2(n_req_p);

    logic [ptr_w_lp-1:0]  ptr_q, ptr_d;
    logic [ptr_w_lp-1:0]  grant_idx;
    logic [ptr_w_lp-1:0]  scan_idx;
    logic                 grant_found;
    logic [n_req_p-1:0]   ready;
    int                   scan_sum;

    logic [wd_addr_p-1:0] win_addr;
    logic [wd_regs_p-1:0] win_data;

    logic                 wr_en_q, wr_en_d;
    logic [wd_addr_p-1:0] wr_addr_q, wr_addr_d;
    logic [wd_regs_p-1:0] wr_data_q, wr_data_d;

    // Scan requesters starting at the pointer; the first valid one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        scan_sum    = 0;
        ready       = '0;
        if (rst_n) begin
            for (int i = 0; i < n_req_p; i++) begin
                scan_sum = int'(ptr_q) + i;
                if (scan_sum >= n_req_p) begin
                    scan_sum = scan_sum - n_req_p;
                end
                scan_idx = ptr_w_lp'(scan_sum);
                if (!grant_found && i_req_valid[scan_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
            if (grant_found) begin
                ready[grant_idx] = 1'b1;
            end
        end
    end

    assign o_req_ready = ready;
    assign win_addr    = i_req_addr[grant_idx];
    assign win_data    = i_req_data[grant_idx];

    // Register 0 is hardwired, so its writebacks are accepted but never written.
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_found) begin
            ptr_d = (int'(grant_idx) == n_req_p - 1) ? '0 : grant_idx + 1'b1;
            if (win_addr != '0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = win_addr;
                wr_data_d = win_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_reg_wr_en   = wr_en_q;
    assign o_reg_wr_addr = wr_addr_q;
    assign o_reg_wr_data = wr_data_q;

`ifdef WB_ARBITER_SCOREBOARD_EN
    logic [n_regs_p-1:0] busy_q, busy_d;

    // Set is applied after clear so a same-edge issue keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (i_issue_en && (i_issue_rd != '0)) begin
            busy_d[i_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{i_issue_en, i_issue_rd};
    assign o_busy       = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with two requesters; scoreboard checks follow WB_ARBITER_SCOREBOARD_EN.
module tb_wb_arbiter;

    localparam int n_req_p   = 2;
    localparam int n_regs_p  = 32;
    localparam int wd_regs_p = 32;
    localparam int wd_addr_p = 5;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic [n_req_p-1:0]                 i_req_valid;
    logic [n_req_p-1:0]                 o_req_ready;
    logic [n_req_p-1:0][wd_addr_p-1:0]  i_req_addr;
    logic [n_req_p-1:0][wd_regs_p-1:0]  i_req_data;
    logic                               o_reg_wr_en;
    logic [wd_addr_p-1:0]               o_reg_wr_addr;
    logic [wd_regs_p-1:0]               o_reg_wr_data;
    logic                               i_issue_en;
    logic [wd_addr_p-1:0]               i_issue_rd;
    logic [n_regs_p-1:0]                o_busy;

    int vectors     = 0;
    int miscompares = 0;

    wb_arbiter #(
        .n_req_p   (n_req_p),
        .n_regs_p  (n_regs_p),
        .wd_regs_p (wd_regs_p)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .o_reg_wr_en   (o_reg_wr_en),
        .o_reg_wr_addr (o_reg_wr_addr),
        .o_reg_wr_data (o_reg_wr_data),
        .i_issue_en    (i_issue_en),
        .i_issue_rd    (i_issue_rd),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n       = 1'b0;
        i_req_valid = 2'b11;
        i_req_addr  = '{5'd6, 5'd5};
        i_req_data  = '{32'hBBBB, 32'hAAAA};
        i_issue_en  = 1'b0;
        i_issue_rd  = '0;
        #1;
        vectors++;
        if (o_req_ready !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 00", o_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b0 || o_reg_wr_addr !== 5'd0 || o_reg_wr_data !== 32'd0 || o_busy !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got en=%b addr=%0d data=%h busy=%h expected all zero",
                     o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data, o_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ready;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c != 0) @(negedge clk);
            exp_ready = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr  = (c % 2 == 0) ? 5'd5 : 5'd6;
            exp_data  = (c % 2 == 0) ? 32'hAAAA : 32'hBBBB;
            #1;
            vectors++;
            if (o_req_ready !== exp_ready) begin
                miscompares++;
                $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", c, o_req_ready, exp_ready);
            end
            @(posedge clk); #1;
            vectors++;
            if (o_reg_wr_en !== 1'b1 || o_reg_wr_addr !== exp_addr || o_reg_wr_data !== exp_data) begin
                miscompares++;
                $display("[TB] FAIL rr_write[%0d]: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                         c, o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data, exp_addr, exp_data);
            end
        end
        @(negedge clk);
        i_req_valid = 2'b00;
        #1;
        vectors++;
        if (o_req_ready !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL idle_ready: got %b expected 00", o_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b0 || o_reg_wr_addr !== 5'd6 || o_reg_wr_data !== 32'hBBBB) begin
            miscompares++;
            $display("[TB] FAIL idle_hold: got en=%b addr=%0d data=%h expected en=0 addr=6 data=0000bbbb",
                     o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        i_req_valid   = 2'b10;
        i_req_addr[1] = 5'd3;
        i_req_data[1] = 32'h1234;
        #1;
        vectors++;
        if (o_req_ready !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL single_ready: got %b expected 10", o_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b1 || o_reg_wr_addr !== 5'd3 || o_reg_wr_data !== 32'h1234) begin
            miscompares++;
            $display("[TB] FAIL single_write: got en=%b addr=%0d data=%h expected en=1 addr=3 data=00001234",
                     o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data);
        end
        @(negedge clk);
        i_req_valid = 2'b00;
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b0 || o_reg_wr_addr !== 5'd3) begin
            miscompares++;
            $display("[TB] FAIL single_after: got en=%b addr=%0d expected en=0 addr=3", o_reg_wr_en, o_reg_wr_addr);
        end
    endtask

    task automatic test_addr_zero();
        @(negedge clk);
        i_req_valid   = 2'b01;
        i_req_addr[0] = 5'd0;
        i_req_data[0] = 32'hFFFF;
        #1;
        vectors++;
        if (o_req_ready !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL zero_ready: got %b expected 01", o_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b0 || o_reg_wr_addr !== 5'd3 || o_reg_wr_data !== 32'h1234 || o_busy !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL zero_write: got en=%b addr=%0d data=%h busy=%h expected en=0 addr=3 data=00001234 busy=0",
                     o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data, o_busy);
        end
        // The accepted addr-0 request advanced the pointer, so req1 wins the tie.
        @(negedge clk);
        i_req_valid = 2'b11;
        i_req_addr  = '{5'd6, 5'd5};
        i_req_data  = '{32'hBBBB, 32'hAAAA};
        #1;
        vectors++;
        if (o_req_ready !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL zero_ptr_ready: got %b expected 10", o_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b1 || o_reg_wr_addr !== 5'd6) begin
            miscompares++;
            $display("[TB] FAIL zero_ptr_write: got en=%b addr=%0d expected en=1 addr=6", o_reg_wr_en, o_reg_wr_addr);
        end
        @(negedge clk);
        i_req_valid = 2'b00;
    endtask

`ifdef WB_ARBITER_SCOREBOARD_EN
    task automatic test_scoreboard();
        @(negedge clk);
        i_issue_en = 1'b1;
        i_issue_rd = 5'd7;
        @(posedge clk); #1;
        vectors++;
        if (o_busy !== (32'd1 << 7)) begin
            miscompares++;
            $display("[TB] FAIL sb_set: got %h expected 00000080", o_busy);
        end
        @(negedge clk);
        i_issue_rd = 5'd0;
        @(posedge clk); #1;
        vectors++;
        if (o_busy !== (32'd1 << 7)) begin
            miscompares++;
            $display("[TB] FAIL sb_rd0: got %h expected 00000080", o_busy);
        end
        @(negedge clk);
        i_issue_en    = 1'b0;
        i_req_valid   = 2'b01;
        i_req_addr[0] = 5'd7;
        i_req_data[0] = 32'h77;
        @(posedge clk); #1;
        vectors++;
        if (o_busy !== (32'd1 << 7) || o_reg_wr_en !== 1'b1 || o_reg_wr_addr !== 5'd7) begin
            miscompares++;
            $display("[TB] FAIL sb_pending: got busy=%h en=%b addr=%0d expected busy=00000080 en=1 addr=7",
                     o_busy, o_reg_wr_en, o_reg_wr_addr);
        end
        @(negedge clk);
        i_req_valid = 2'b00;
        @(posedge clk); #1;
        vectors++;
        if (o_busy !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL sb_clear: got %h expected 00000000", o_busy);
        end
        @(negedge clk);
        i_issue_en  = 1'b1;
        i_issue_rd  = 5'd7;
        i_req_valid = 2'b01;
        @(posedge clk); #1;
        @(negedge clk);
        i_req_valid = 2'b00;
        @(posedge clk); #1;
        vectors++;
        if (o_busy !== (32'd1 << 7)) begin
            miscompares++;
            $display("[TB] FAIL sb_set_wins: got %h expected 00000080", o_busy);
        end
        @(negedge clk);
        i_issue_en  = 1'b0;
        i_req_valid = 2'b01;
        @(negedge clk);
        i_req_valid = 2'b00;
        @(posedge clk); #1;
        vectors++;
        if (o_busy !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL sb_final_clear: got %h expected 00000000", o_busy);
        end
    endtask
`else
    task automatic test_issue_ignored();
        @(negedge clk);
        i_issue_en = 1'b1;
        i_issue_rd = 5'd4;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (o_busy !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL nosb_busy[%0d]: got %h expected 00000000", c, o_busy);
            end
        end
        @(negedge clk);
        i_issue_en = 1'b0;
        i_issue_rd = '0;
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] exp_busy;
`ifdef WB_ARBITER_SCOREBOARD_EN
        exp_busy = 32'd1 << 9;
`else
        exp_busy = 32'd0;
`endif
        @(negedge clk);
        i_req_valid   = 2'b01;
        i_req_addr[0] = 5'd9;
        i_req_data[0] = 32'h9999;
        i_issue_en    = 1'b1;
        i_issue_rd    = 5'd9;
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b1 || o_reg_wr_addr !== 5'd9 || o_busy !== exp_busy) begin
            miscompares++;
            $display("[TB] FAIL mid_pending: got en=%b addr=%0d busy=%h expected en=1 addr=9 busy=%h",
                     o_reg_wr_en, o_reg_wr_addr, o_busy, exp_busy);
        end
        @(negedge clk);
        rst_n       = 1'b0;
        i_issue_en  = 1'b0;
        i_req_valid = 2'b11;
        i_req_addr  = '{5'd6, 5'd5};
        i_req_data  = '{32'hBBBB, 32'hAAAA};
        #1;
        vectors++;
        if (o_req_ready !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL mid_ready: got %b expected 00", o_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b0 || o_reg_wr_addr !== 5'd0 || o_reg_wr_data !== 32'd0 || o_busy !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got en=%b addr=%0d data=%h busy=%h expected all zero",
                     o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data, o_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (o_req_ready !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL mid_tie: got %b expected 01", o_req_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (o_reg_wr_en !== 1'b1 || o_reg_wr_addr !== 5'd5 || o_reg_wr_data !== 32'hAAAA) begin
            miscompares++;
            $display("[TB] FAIL mid_tie_write: got en=%b addr=%0d data=%h expected en=1 addr=5 data=0000aaaa",
                     o_reg_wr_en, o_reg_wr_addr, o_reg_wr_data);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (o_req_ready !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL mid_next: got %b expected 10", o_req_ready);
        end
        i_req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_addr_zero();
`ifdef WB_ARBITER_SCOREBOARD_EN
        test_scoreboard();
`else
        test_issue_ignored();
`endif
        test_reset_mid();
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter n_req_p, default 2: number of writeback requesters, range 2..4.
REQ-002 Parameter n_regs_p, default 32: architectural registers; wd_addr_p = $clog2(n_regs_p).
REQ-003 Parameter wd_regs_p, default 32: register data width.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_req_valid  input  [n_req_p-1:0]  requester k holds a writeback.
REQ-007 o_req_ready  output  [n_req_p-1:0]  grant to requester k; one-hot or zero.
REQ-008 i_req_addr  input  [n_req_p-1:0][wd_addr_p-1:0]  destination register per requester.
REQ-009 i_req_data  input  [n_req_p-1:0][wd_regs_p-1:0]  writeback data per requester.
REQ-010 o_reg_wr_en  output  1  register file write enable.
REQ-011 o_reg_wr_addr  output  wd_addr_p  register file write address.
REQ-012 o_reg_wr_data  output  wd_regs_p  register file write data.
REQ-013 i_issue_en  input  1  an instruction with a destination register issues this cycle.
REQ-014 i_issue_rd  input  wd_addr_p  destination of the issuing instruction.
REQ-015 o_busy  output  n_regs_p  per-register pending-writeback scoreboard.

Function
REQ-016 o_req_ready SHALL be combinational: asserted only for the single winning valid requester; all zero when no requester is valid.
REQ-017 Arbitration SHALL be round-robin: search starts at priority pointer ptr, increasing index modulo n_req_p; first valid requester wins.
REQ-018 On a handshake (valid & ready) by requester g, ptr SHALL update to (g+1) mod n_req_p on the next edge; ptr SHALL hold when no handshake occurs.
REQ-019 A requester SHALL keep valid, addr and data stable until ready; the arbiter never drops an accepted request.
REQ-020 Output SHALL be registered: handshake at edge N drives o_reg_wr_en=1 with the winner's addr/data during cycle N+1 (latency 1); o_reg_wr_en=0 in cycles with no prior-cycle handshake.
REQ-021 A handshake with addr 0 SHALL be accepted (ready asserted) but SHALL produce o_reg_wr_en=0.
REQ-022 The arbiter SHALL sustain one handshake per cycle; register file write port never back-pressures.
REQ-023 o_busy[i_issue_rd] SHALL set on the edge where i_issue_en=1 and i_issue_rd != 0.
REQ-024 o_busy[k] SHALL clear on the edge where o_reg_wr_en=1 and o_reg_wr_addr=k.
REQ-025 Set and clear of the same bit on the same edge: set SHALL win.
REQ-026 o_busy[0] SHALL always read 0.
REQ-027 o_reg_wr_data, o_reg_wr_addr SHALL hold their last value while o_reg_wr_en=0.

Reset
REQ-028 With rst_n=0 at a rising edge: ptr=0, o_reg_wr_en=0, o_reg_wr_addr=0, o_reg_wr_data=0, o_busy=0.
REQ-029 While rst_n=0, o_req_ready SHALL be all zero; no handshake occurs.
REQ-030 Reset asserted mid-stream SHALL discard a registered pending write (o_reg_wr_en=0 in the following cycle).

Configuration
REQ-031 Macro WB_ARBITER_SCOREBOARD_EN defined: scoreboard per REQ-023..026 is built.
REQ-032 Macro WB_ARBITER_SCOREBOARD_EN undefined: no scoreboard storage; o_busy tied to 0; i_issue_en, i_issue_rd ignored; all other behaviour unchanged.

Verification
REQ-033 n_req_p=2, both valid (addr 5/data 0xAAAA, addr 6/data 0xBBBB) held from reset release -> ready alternates 01,10,01,...; wr_en=1 next cycle with matching addr/data each cycle.
REQ-034 Only req1 valid, addr 3, data 0x1234, single cycle -> ready=10 that cycle; next cycle wr_en=1, wr_addr=3, wr_data=0x1234; following cycle wr_en=0.
REQ-035 req0 valid addr 0, data 0xFFFF -> ready=01; next cycle wr_en=0; o_busy unchanged.
REQ-036 (SCOREBOARD_EN) issue rd=7 -> busy[7]=1; writeback addr 7 handshake at edge N -> busy[7]=0 after edge N+1; issue rd=7 in same cycle as wr_en addr 7 -> busy[7] stays 1.
REQ-037 rst_n=0 asserted in cycle after handshake to addr 9 -> wr_en=0, o_busy=0, ptr=0; after release req0 wins first tie.
REQ-038 Without WB_ARBITER_SCOREBOARD_EN: issue rd=4 -> o_busy stays 0; arbitration results identical to REQ-033.
